// File: rtl/eq_sched_pkg.sv
// Shared sizing and tag type for the equation-pipeline scheduler.
package eq_sched_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned LAT  = 3;
    localparam int unsigned DW   = 8;
    localparam int unsigned EW   = 16;
    localparam int unsigned IDW  = $clog2(NREQ);
    localparam int unsigned CW   = $clog2(LAT + 1);

    // One shadow-pipeline entry: occupancy flag plus originating requester.
    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, pointer advances past the winner on accept.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic                     enable,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     grant_valid
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] idx;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input int unsigned off);
        return IDW'((32'(base) + off) % NREQ);
    endfunction

    // Pick the first requesting index at or after ptr, wrapping modulo NREQ.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = wrap_add(ptr_q, k);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
        if (grant_valid) begin
            grant[grant_id] = 1'b1;
        end
    end

    // Pointer moves only when the grant is actually consumed.
    always_comb begin
        ptr_d = ptr_q;
        if (enable && grant_valid) begin
            ptr_d = wrap_add(grant_id, 1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/eq_pipe_sched.sv
// Shares one fixed-latency equation datapath between NREQ requesters and tags each
// result with its originating requester. Sizing comes from eq_sched_pkg.
module eq_pipe_sched
    import eq_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*DW-1:0]  req_a,
    input  logic [NREQ*DW-1:0]  req_b,
    input  logic [NREQ*DW-1:0]  req_c,
    output logic [DW-1:0]       op_a,
    output logic [DW-1:0]       op_b,
    output logic [DW-1:0]       op_c,
    output logic                pipe_en,
    input  logic [EW-1:0]       pipe_e,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [EW-1:0]       rsp_e,
    output logic [CW-1:0]       inflight
);

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_valid;
    logic            accept;
    logic            rsp_fire;
    tag_t            tags_q [LAT];
    logic [CW-1:0]   inflight_q, inflight_d;

    // A waiting result freezes the whole pipe, so no skid storage is needed.
    assign pipe_en  = !(rsp_valid && !rsp_ready);
    assign accept   = pipe_en && grant_valid;
    assign rsp_fire = rsp_valid && rsp_ready;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req_valid),
        .enable      (pipe_en),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // grant is already zero without a winner, so gating by pipe_en suffices.
    assign req_ready = pipe_en ? grant : '0;

    // Route the winner's operands to the datapath; zeros when nobody is granted.
    always_comb begin
        op_a = '0;
        op_b = '0;
        op_c = '0;
        if (grant_valid) begin
            op_a = req_a[32'(grant_id)*DW +: DW];
            op_b = req_b[32'(grant_id)*DW +: DW];
            op_c = req_c[32'(grant_id)*DW +: DW];
        end
    end

    // Shadow tag pipeline advancing in lockstep with the datapath stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                tags_q[k] <= '0;
            end
        end else if (pipe_en) begin
            tags_q[0] <= '{vld: accept, id: grant_id};
            for (int unsigned k = 1; k < LAT; k++) begin
                tags_q[k] <= tags_q[k-1];
            end
        end
    end

    assign rsp_valid = tags_q[LAT-1].vld;
    assign rsp_id    = tags_q[LAT-1].id;
    assign rsp_e     = pipe_e;

    // Occupancy: stalls imply neither accept nor response, so it holds for free.
    always_comb begin
        inflight_d = inflight_q;
        case ({accept, rsp_fire})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign inflight = inflight_q;

endmodule
